// File: rtl/sar_adc_scan_controller.sv
// sar_adc_scan_controller: SAR ADC sequencer scanning masked mux channels with optional averaging.
module sar_adc_scan_controller #(
  parameter int WIDTH         = 8,
  parameter int NCH           = 4,
  parameter int SAMPLE_CYCLES = 2,
  parameter int AVG_LOG2      = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_en,
  input  logic                   i_start,
  input  logic                   i_cont,
  input  logic                   i_stop,
  input  logic [NCH-1:0]         i_ch_mask,
  input  logic                   i_cmp,
  output logic                   o_sample,
  output logic [WIDTH-1:0]       o_value,
  output logic [$clog2(NCH)-1:0] o_ch_sel,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_result,
  output logic [$clog2(NCH)-1:0] o_result_ch,
  output logic                   o_scan_done
);
  localparam int CW   = $clog2(NCH);
  localparam int SW   = $clog2(SAMPLE_CYCLES + 1);
  localparam int AW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACCW = WIDTH + AVG_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONV, S_DONE} state_t;

  state_t            r_state, w_state_nx;
  logic              r_pending, w_pending_nx;
  logic [NCH-1:0]    r_mask, w_mask_nx;
  logic [CW-1:0]     r_ch, w_ch_nx;
  logic [SW-1:0]     r_scnt, w_scnt_nx;
  logic [WIDTH-1:0]  r_bit, w_bit_nx;
  logic [WIDTH-1:0]  r_work, w_work_nx;
  logic [AW-1:0]     r_avg, w_avg_nx;
  logic [ACCW-1:0]   r_acc, w_acc_nx;
  logic [WIDTH-1:0]  r_result, w_result_nx;
  logic [CW-1:0]     r_result_ch, w_result_ch_nx;
  logic [CW-1:0]     w_low, w_nxt;
  logic              w_found;
  logic [WIDTH-1:0]  w_conv;
  logic [ACCW-1:0]   w_acc_sum;

  // lowest channel of the incoming mask and next latched channel above the current one
  always_comb begin
    w_low   = '0;
    w_nxt   = '0;
    w_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (i_ch_mask[i]) w_low = CW'(i);
      if (r_mask[i] && CW'(i) > r_ch) begin
        w_nxt   = CW'(i);
        w_found = 1'b1;
      end
    end
  end

  assign w_conv    = i_cmp ? (r_work | r_bit) : r_work;
  assign w_acc_sum = r_acc + ACCW'(w_conv);

  always_comb begin
    w_state_nx     = r_state;
    w_pending_nx   = r_pending;
    w_mask_nx      = r_mask;
    w_ch_nx        = r_ch;
    w_scnt_nx      = r_scnt;
    w_bit_nx       = r_bit;
    w_work_nx      = r_work;
    w_avg_nx       = r_avg;
    w_acc_nx       = r_acc;
    w_result_nx    = r_result;
    w_result_ch_nx = r_result_ch;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_pending_nx = 1'b1;
        if (i_en && (i_start || r_pending || i_cont)) begin
          w_pending_nx = 1'b0;
          if (|i_ch_mask) begin
            w_mask_nx  = i_ch_mask;
            w_ch_nx    = w_low;
            w_avg_nx   = '0;
            w_acc_nx   = '0;
            w_scnt_nx  = '0;
            w_state_nx = S_SAMPLE;
          end
        end
      end
      S_SAMPLE: begin
        if (i_en) begin
          w_scnt_nx = r_scnt + 1'b1;
          if (r_scnt == SW'(SAMPLE_CYCLES - 1)) begin
            w_scnt_nx  = '0;
            w_bit_nx   = {1'b1, {(WIDTH-1){1'b0}}};
            w_work_nx  = '0;
            w_state_nx = S_CONV;
          end
        end
      end
      S_CONV: begin
        if (i_en) begin
          w_work_nx = w_conv;
          w_bit_nx  = r_bit >> 1;
          if (r_bit[0]) begin
            w_acc_nx = w_acc_sum;
            if (r_avg == AW'((1 << AVG_LOG2) - 1)) begin
              w_result_nx    = WIDTH'(w_acc_sum >> AVG_LOG2);
              w_result_ch_nx = r_ch;
              w_state_nx     = S_DONE;
            end else begin
              w_avg_nx   = r_avg + 1'b1;
              w_state_nx = S_SAMPLE;
            end
          end
        end
      end
      S_DONE: begin
        w_avg_nx   = '0;
        w_acc_nx   = '0;
        w_state_nx = S_SAMPLE;
        if (w_found) w_ch_nx = w_nxt;
        else if (i_cont && |i_ch_mask) begin
          w_mask_nx = i_ch_mask;
          w_ch_nx   = w_low;
        end else w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (i_stop) begin
      w_state_nx   = S_IDLE;
      w_pending_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pending   <= 1'b0;
      r_mask      <= '0;
      r_ch        <= '0;
      r_scnt      <= '0;
      r_bit       <= '0;
      r_work      <= '0;
      r_avg       <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_result_ch <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_pending   <= w_pending_nx;
      r_mask      <= w_mask_nx;
      r_ch        <= w_ch_nx;
      r_scnt      <= w_scnt_nx;
      r_bit       <= w_bit_nx;
      r_work      <= w_work_nx;
      r_avg       <= w_avg_nx;
      r_acc       <= w_acc_nx;
      r_result    <= w_result_nx;
      r_result_ch <= w_result_ch_nx;
    end
  end

  assign o_sample    = r_state == S_SAMPLE;
  assign o_value     = (r_state == S_CONV) ? (r_work | r_bit) : '0;
  assign o_ch_sel    = r_ch;
  assign o_busy      = r_state != S_IDLE;
  assign o_valid     = r_state == S_DONE;
  assign o_result    = r_result;
  assign o_result_ch = r_result_ch;
  assign o_scan_done = (r_state == S_DONE) && !w_found;
endmodule
